// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core widths, ALU encodings and helpers
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ALUCTRL_W  = 3;

  typedef enum logic [ALUCTRL_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluOp_e;

  // Destination register select: R-type writes rd, I-type writes rt.
  function automatic logic [REG_ADDR_W-1:0] selWriteReg(
    input logic                  regDst,
    input logic [REG_ADDR_W-1:0] rt,
    input logic [REG_ADDR_W-1:0] rd
  );
    return regDst ? rd : rt;
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// rtl/pipe_field_reg.sv - W-bit pipeline field register with flush clear and enable
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear beats enable so a flush during a stall still inserts a bubble.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - decode-to-execute pipeline register with bubble counter
module id_ex_pipe_reg
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FlushE,
  input  logic                  StallE,
  input  logic                  BubbleClr,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  MemWriteD,
  input  logic                  ALUSrcD,
  input  logic                  RegDstD,
  input  logic [ALUCTRL_W-1:0]  ALUControlD,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [DATA_WIDTH-1:0] SignImmD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RdD,
  output logic                  RegWriteE,
  output logic                  MemtoRegE,
  output logic                  MemWriteE,
  output logic                  ALUSrcE,
  output logic [ALUCTRL_W-1:0]  ALUControlE,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] SignImmE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [REG_ADDR_W-1:0] RsE,
  output logic [REG_ADDR_W-1:0] RtE,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [REG_ADDR_W-1:0] WriteRegE,
  output logic                  ValidE,
  output logic [CNT_WIDTH-1:0]  BubbleCount
);

  localparam int CTRL_W = 6 + ALUCTRL_W;
  localparam int DATA_W = 4 * DATA_WIDTH;
  localparam int REGS_W = 3 * REG_ADDR_W;

  logic              loadEn;
  logic              regDstE;
  logic [CTRL_W-1:0] ctrlD, ctrlQ;
  logic [DATA_W-1:0] dataD, dataQ;
  logic [REGS_W-1:0] regsD, regsQ;

  assign loadEn = ~StallE;

  // ValidE rides in the control group: loads 1 on a real load, 0 on flush/reset.
  assign ctrlD = {1'b1, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD};
  assign dataD = {RD1D, RD2D, SignImmD, PCPlus4D};
  assign regsD = {RsD, RtD, RdD};

  pipe_field_reg #(.W(CTRL_W)) uCtrl (
    .clk  (CLK),
    .rstN (RST),
    .clr  (FlushE),
    .en   (loadEn),
    .d    (ctrlD),
    .q    (ctrlQ)
  );

  pipe_field_reg #(.W(DATA_W)) uData (
    .clk  (CLK),
    .rstN (RST),
    .clr  (FlushE),
    .en   (loadEn),
    .d    (dataD),
    .q    (dataQ)
  );

  pipe_field_reg #(.W(REGS_W)) uRegs (
    .clk  (CLK),
    .rstN (RST),
    .clr  (FlushE),
    .en   (loadEn),
    .d    (regsD),
    .q    (regsQ)
  );

  assign {ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, regDstE, ALUControlE} = ctrlQ;
  assign {RD1E, RD2E, SignImmE, PCPlus4E} = dataQ;
  assign {RsE, RtE, RdE} = regsQ;

  assign WriteRegE = selWriteReg(regDstE, RtE, RdE);

  // Bubble counter counts flushes regardless of stall and sticks at all-ones.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      BubbleCount <= '0;
    end else if (BubbleClr) begin
      BubbleCount <= '0;
    end else if (FlushE && (BubbleCount != {CNT_WIDTH{1'b1}})) begin
      BubbleCount <= BubbleCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          FlushE, StallE, BubbleClr;
  logic          RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]    ALUControlD;
  logic [DW-1:0] RD1D, RD2D, SignImmD, PCPlus4D;
  logic [4:0]    RsD, RtD, RdD;
  logic          RegWriteE, MemtoRegE, MemWriteE, ALUSrcE;
  logic [2:0]    ALUControlE;
  logic [DW-1:0] RD1E, RD2E, SignImmE, PCPlus4E;
  logic [4:0]    RsE, RtE, RdE, WriteRegE;
  logic          ValidE;
  logic [CW-1:0] BubbleCount;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  id_ex_pipe_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .FlushE(FlushE), .StallE(StallE), .BubbleClr(BubbleClr),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD), .PCPlus4D(PCPlus4D),
    .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .PCPlus4E(PCPlus4E),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .WriteRegE(WriteRegE),
    .ValidE(ValidE), .BubbleCount(BubbleCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; FlushE = 1'b0; StallE = 1'b0; BubbleClr = 1'b0;
    RegWriteD = 1'b1; MemtoRegD = 1'b1; MemWriteD = 1'b1; ALUSrcD = 1'b1; RegDstD = 1'b1;
    ALUControlD = 3'b110;
    RD1D = 32'hAAAA_0001; RD2D = 32'hBBBB_0002; SignImmD = 32'hCCCC_0003; PCPlus4D = 32'h0000_0104;
    RsD = 5'd1; RtD = 5'd2; RdD = 5'd31;

    // Asynchronous reset with nonzero inputs, before and across an edge
    #3;
    chk("rst_valid_async", ValidE, 0);
    chk("rst_writereg_async", WriteRegE, 0);
    step();
    chk("rst_regwrite", RegWriteE, 0);
    chk("rst_memtoreg", MemtoRegE, 0);
    chk("rst_memwrite", MemWriteE, 0);
    chk("rst_alusrc", ALUSrcE, 0);
    chk("rst_aluctrl", ALUControlE, 0);
    chk("rst_rd1", RD1E, 0);
    chk("rst_pcplus4", PCPlus4E, 0);
    chk("rst_rs", RsE, 0);
    chk("rst_rt", RtE, 0);
    chk("rst_rd", RdE, 0);
    chk("rst_valid", ValidE, 0);
    chk("rst_bubble", BubbleCount, 0);
    chk("rst_writereg", WriteRegE, 0);

    // First load after reset release
    RST = 1'b1;
    RsD = 5'd3; RtD = 5'd5; RdD = 5'd7; RegDstD = 1'b1;
    step();
    chk("load1_rs", RsE, 3);
    chk("load1_rt", RtE, 5);
    chk("load1_writereg", WriteRegE, 7);
    chk("load1_valid", ValidE, 1);
    chk("load1_aluctrl", ALUControlE, 3'b110);
    chk("load1_rd2", RD2E, 32'hBBBB_0002);
    chk("load1_signimm", SignImmE, 32'hCCCC_0003);
    chk("load1_memwrite", MemWriteE, 1);

    // WriteRegE mux: rt path then rd path
    RegDstD = 1'b0; RtD = 5'd9; RD1D = 32'h1234_5678;
    ALUSrcD = 1'b0; ALUControlD = 3'b010;
    step();
    chk("mux_rt_writereg", WriteRegE, 9);
    chk("mux_rt_rd1", RD1E, 32'h1234_5678);
    chk("mux_rt_alusrc", ALUSrcE, 0);
    chk("mux_rt_aluctrl", ALUControlE, 3'b010);
    RegDstD = 1'b1; RdD = 5'd12;
    step();
    chk("mux_rd_writereg", WriteRegE, 12);

    // Flush inserts a bubble
    RegWriteD = 1'b1; MemtoRegD = 1'b1; RsD = 5'd4; FlushE = 1'b1;
    step();
    chk("flush_regwrite", RegWriteE, 0);
    chk("flush_memtoreg", MemtoRegE, 0);
    chk("flush_rs", RsE, 0);
    chk("flush_valid", ValidE, 0);
    chk("flush_writereg", WriteRegE, 0);
    chk("flush_rd1", RD1E, 0);
    chk("flush_bubble", BubbleCount, 1);

    // Stall hold
    FlushE = 1'b0; RtD = 5'd6; RegDstD = 1'b0;
    step();
    chk("pre_stall_rt", RtE, 6);
    chk("pre_stall_valid", ValidE, 1);
    StallE = 1'b1; RtD = 5'd10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rt", RtE, 6);
      chk("stall_valid", ValidE, 1);
      chk("stall_writereg", WriteRegE, 6);
    end
    chk("stall_bubble", BubbleCount, 1);
    StallE = 1'b0;
    step();
    chk("unstall_rt", RtE, 10);

    // Flush and stall together: flush wins
    FlushE = 1'b1; StallE = 1'b1;
    step();
    chk("flushstall_valid", ValidE, 0);
    chk("flushstall_rt", RtE, 0);
    chk("flushstall_regwrite", RegWriteE, 0);
    chk("flushstall_bubble", BubbleCount, 2);

    // Stalled bubble stays a bubble
    FlushE = 1'b0;
    step();
    chk("stall_bubble_valid", ValidE, 0);
    chk("stall_bubble_cnt", BubbleCount, 2);

    // Reset asserted mid-stall clears immediately; first free edge reloads
    StallE = 1'b0; RtD = 5'd17;
    step();
    chk("prereset_valid", ValidE, 1);
    StallE = 1'b1;
    step();
    RST = 1'b0;
    #1;
    chk("midstall_rst_valid", ValidE, 0);
    chk("midstall_rst_rt", RtE, 0);
    chk("midstall_rst_bubble", BubbleCount, 0);
    step();
    RST = 1'b1; StallE = 1'b0;
    step();
    chk("post_rst_valid", ValidE, 1);
    chk("post_rst_rt", RtE, 17);

    // Counter saturation and clear
    FlushE = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("sat_reach15", BubbleCount, 15);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold15", BubbleCount, 15);
    BubbleClr = 1'b1;
    step();
    chk("clr_priority", BubbleCount, 0);
    BubbleClr = 1'b0;
    step();
    chk("clr_resume", BubbleCount, 1);
    FlushE = 1'b0;
    step();
    chk("noflush_hold", BubbleCount, 1);
    chk("noflush_valid", ValidE, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Decode-to-execute pipeline register of the 5-stage MIPS core. It captures decode-stage control, operands and register specifiers on each rising clock edge. It honours the hazard unit's FlushE, which inserts a bubble, and a StallE hold for multi-cycle EX extensions. It drives the E-stage signals consumed by the hazard unit and the EX datapath: RsE, RtE, WriteRegE, RegWriteE and MemtoRegE. It also keeps a saturating count of inserted bubbles for performance debug.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/PC width
- CNT_WIDTH, 16, bubble counter width

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-low reset
- FlushE  in  1  insert bubble (from hazard unit)
- StallE  in  1  hold current contents
- BubbleClr  in  1  synchronous clear of bubble counter
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode control
- ALUControlD  in  3  ALU operation
- RD1D, RD2D, SignImmD, PCPlus4D  in  DATA_WIDTH each  operands
- RsD, RtD, RdD  in  5 each  register specifiers
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE  out  1 each  registered control
- ALUControlE  out  3
- RD1E, RD2E, SignImmE, PCPlus4E  out  DATA_WIDTH each
- RsE, RtE, RdE  out  5 each
- WriteRegE  out  5  destination register (RtE or RdE)
- ValidE  out  1  1 = real instruction, 0 = bubble/reset
- BubbleCount  out  CNT_WIDTH  saturating count of flush cycles

## Operation
- Reset (RST=0, asynchronous): every registered output goes to 0, including ValidE=0 and BubbleCount=0. WriteRegE therefore reads 0.
- Per-edge priority: reset > FlushE > StallE > load.
- FlushE=1:
  - All control bits, ALUControlE, RsE/RtE/RdE, RegDstE and data fields load 0.
  - ValidE loads 0.
  - The resulting bubble has RegWriteE=0, MemtoRegE=0 and register specifiers of 0, so the hazard unit sees no dependency.
- StallE=1 with FlushE=0: all fields hold, including ValidE.
- Otherwise: every xD input loads into its xE register, and ValidE loads 1.
- WriteRegE = RegDstE ? RdE : RtE. This is combinational from registered fields, with no extra latency. RegDstE is internal.
- BubbleCount:
  - +1 on every edge with FlushE=1, including while StallE=1.
  - Saturates at all-ones.
  - BubbleClr=1 loads 0 and takes priority over increment.
  - Independent of StallE.

## Timing
- Latency: 1 cycle, D inputs to E outputs.
- FlushE and StallE are sampled at the same edge as the data they act on. They are expected to come combinationally from the hazard unit in the same cycle.
- Simultaneous FlushE and StallE: flush wins, so a bubble is loaded.
- Reset asserted mid-stall: outputs clear immediately. After reset deasserts, the first edge with FlushE=StallE=0 loads D and sets ValidE=1.
- Counter wrap: none. At 2^CNT_WIDTH−1 it holds until BubbleClr.

## Structure
- Shared package mips_pkg holds:
  - REG_ADDR_W = 5
  - ALUCTRL_W = 3
  - the ALU operation encodings
- One natural sub-module, pipe_field_reg (parameter W). It is a W-bit register with async active-low reset, a clr input (flush) and an en input (not stall). It is instantiated once per field group.
- Counter and WriteRegE mux live in the top module.

## Test plan
- Reset: assert RST=0 with all D inputs at nonzero values → all outputs 0, ValidE=0, BubbleCount=0, WriteRegE=0. Release RST, then one edge with RsD=3, RtD=5, RdD=7, RegDstD=1 → RsE=3, RtE=5, WriteRegE=7, ValidE=1.
- Load and mux: RegDstD=0, RtD=9, RD1D=0x1234_5678 → after one edge WriteRegE=9 and RD1E=0x1234_5678. Then RegDstD=1, RdD=12 → WriteRegE=12.
- Flush bubble: load RegWriteD=1, MemtoRegD=1, RsD=4, with FlushE=1 → RegWriteE=0, MemtoRegE=0, RsE=0, ValidE=0, BubbleCount=1.
- Stall hold: load RtD=6, then StallE=1 for 3 edges while RtD changes to 10 → RtE stays 6 and ValidE stays 1. Release StallE → RtE=10.
- Flush+stall together: FlushE=StallE=1 → bubble loaded, BubbleCount increments.
- Counter saturation and clear: CNT_WIDTH=4 with 20 flush cycles → BubbleCount=15. BubbleClr=1 together with FlushE=1 → BubbleCount=0.
